// File: rtl/mmc_sector_sequencer.sv
// Multi-sector sequencer: turns host init/read/write requests into MMC controller
// card/buffer commands and a 32-bit valid/ready word stream per 512-byte sector.
module mmc_sector_sequencer #(
  parameter int P_WORDS     = 128,
  parameter int P_TIMEOUT_W = 24
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iINIT,
  input  logic        iSTART,
  input  logic        iDIR,
  input  logic [31:0] iLBA,
  input  logic [15:0] iCOUNT,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERROR,
  output logic [5:0]  oERR_FLAGS,
  output logic [15:0] oSECT_DONE,
  output logic        oRD_VALID,
  output logic [31:0] oRD_DATA,
  input  logic        iRD_READY,
  input  logic        iWR_VALID,
  input  logic [31:0] iWR_DATA,
  output logic        oWR_READY,
  output logic        oMMC_REQ,
  output logic [2:0]  oMMC_COMMAND,
  output logic [31:0] oMMC_ADDR,
  output logic [31:0] oMMC_DATA,
  input  logic        iMMC_BUSY,
  input  logic        iMMC_VALID,
  input  logic [31:0] iMMC_DATA,
  input  logic        iMMC_ERROR,
  input  logic [5:0]  iMMC_FLAGS
);

  localparam int WW = $clog2(P_WORDS);
  localparam logic [WW-1:0] LAST = WW'(P_WORDS - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_INIT_ISS = 4'd1;
  localparam logic [3:0] S_CARD_ISS = 4'd2;
  localparam logic [3:0] S_CARD_WT  = 4'd3;
  localparam logic [3:0] S_BRD_ISS  = 4'd4;
  localparam logic [3:0] S_BRD_WT   = 4'd5;
  localparam logic [3:0] S_RD_OUT   = 4'd6;
  localparam logic [3:0] S_WR_IN    = 4'd7;
  localparam logic [3:0] S_BWR_ISS  = 4'd8;
  localparam logic [3:0] S_BWR_WT   = 4'd9;
  localparam logic [3:0] S_NEXT     = 4'd10;
  localparam logic [3:0] S_FIN      = 4'd11;

  localparam logic [2:0] C_INIT = 3'd0;
  localparam logic [2:0] C_RDC  = 3'd1;
  localparam logic [2:0] C_WRC  = 3'd2;
  localparam logic [2:0] C_RDB  = 3'd3;
  localparam logic [2:0] C_WRB  = 3'd4;

  logic [3:0]             state;
  logic                   is_init;
  logic                   dir;
  logic [31:0]            lba;
  logic [15:0]            rem;
  logic [WW-1:0]          word;
  logic [P_TIMEOUT_W-1:0] wdog;
  logic                   in_wait;
  logic                   fail_err;
  logic                   fail_to;

  assign in_wait  = (state == S_CARD_WT) || (state == S_BRD_WT) ||
                    (state == S_BWR_WT);
  assign fail_err = in_wait && iMMC_VALID && iMMC_ERROR;
  assign fail_to  = in_wait && !iMMC_VALID && (&wdog);

  assign oBUSY     = (state != S_IDLE);
  assign oDONE     = (state == S_FIN);
  assign oRD_VALID = (state == S_RD_OUT);
  assign oWR_READY = (state == S_WR_IN);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state        <= S_IDLE;
      is_init      <= 1'b0;
      dir          <= 1'b0;
      lba          <= '0;
      rem          <= '0;
      word         <= '0;
      wdog         <= '0;
      oERROR       <= 1'b0;
      oERR_FLAGS   <= '0;
      oSECT_DONE   <= '0;
      oRD_DATA     <= '0;
      oMMC_REQ     <= 1'b0;
      oMMC_COMMAND <= '0;
      oMMC_ADDR    <= '0;
      oMMC_DATA    <= '0;
    end else begin
      oMMC_REQ <= 1'b0;
      wdog     <= in_wait ? wdog + 1'b1 : '0;
      if (fail_err || fail_to) begin
        oERROR     <= 1'b1;
        oERR_FLAGS <= fail_err ? iMMC_FLAGS : 6'h02;
        state      <= S_FIN;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (iINIT) begin
              is_init    <= 1'b1;
              oERROR     <= 1'b0;
              oERR_FLAGS <= '0;
              state      <= S_INIT_ISS;
            end else if (iSTART) begin
              if (iCOUNT == '0) begin
                state <= S_FIN;
              end else begin
                is_init    <= 1'b0;
                lba        <= iLBA;
                rem        <= iCOUNT;
                dir        <= iDIR;
                word       <= '0;
                oERROR     <= 1'b0;
                oERR_FLAGS <= '0;
                oSECT_DONE <= '0;
                state      <= iDIR ? S_WR_IN : S_CARD_ISS;
              end
            end
          end
          S_INIT_ISS: if (!iMMC_BUSY) begin
            oMMC_REQ     <= 1'b1;
            oMMC_COMMAND <= C_INIT;
            oMMC_ADDR    <= '0;
            state        <= S_CARD_WT;
          end
          S_CARD_ISS: if (!iMMC_BUSY) begin
            oMMC_REQ     <= 1'b1;
            oMMC_COMMAND <= dir ? C_WRC : C_RDC;
            oMMC_ADDR    <= {lba[22:0], 9'h0};
            state        <= S_CARD_WT;
          end
          S_CARD_WT: if (iMMC_VALID) begin
            word <= '0;
            if (is_init)  state <= S_FIN;
            else if (dir) state <= S_NEXT;
            else          state <= S_BRD_ISS;
          end
          S_BRD_ISS: if (!iMMC_BUSY) begin
            oMMC_REQ     <= 1'b1;
            oMMC_COMMAND <= C_RDB;
            oMMC_ADDR    <= 32'({word, 2'b00});
            state        <= S_BRD_WT;
          end
          S_BRD_WT: if (iMMC_VALID) begin
            oRD_DATA <= iMMC_DATA;
            state    <= S_RD_OUT;
          end
          S_RD_OUT: if (iRD_READY) begin
            word  <= word + 1'b1;
            state <= (word == LAST) ? S_NEXT : S_BRD_ISS;
          end
          S_WR_IN: if (iWR_VALID) begin
            oMMC_DATA <= iWR_DATA;
            state     <= S_BWR_ISS;
          end
          S_BWR_ISS: if (!iMMC_BUSY) begin
            oMMC_REQ     <= 1'b1;
            oMMC_COMMAND <= C_WRB;
            oMMC_ADDR    <= 32'({word, 2'b00});
            state        <= S_BWR_WT;
          end
          S_BWR_WT: if (iMMC_VALID) begin
            word  <= word + 1'b1;
            state <= (word == LAST) ? S_CARD_ISS : S_WR_IN;
          end
          S_NEXT: begin
            oSECT_DONE <= oSECT_DONE + 1'b1;
            lba        <= lba + 1'b1;
            rem        <= rem - 1'b1;
            word       <= '0;
            if (rem == 16'd1) state <= S_FIN;
            else              state <= dir ? S_WR_IN : S_CARD_ISS;
          end
          S_FIN:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
